// File: rtl/varredura_display.sv
// Time-multiplexed scanner for the six clock digits. A dark gap precedes
// each digit. Each digit can blink or light its decimal point.
module varredura_display #(
   parameter int         DWELL_CYCLES  = 50000,
   parameter int         BLANK_CYCLES  = 500,
   parameter int         BLINK_FRAMES  = 250,
   parameter logic [6:0] SEG_OFF       = 7'b1111111,
   parameter bit         AN_ACTIVE_LOW = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [6:0] dig0,
   input  logic [6:0] dig1,
   input  logic [6:0] dig2,
   input  logic [6:0] dig3,
   input  logic [6:0] dig4,
   input  logic [6:0] dig5,
   input  logic [5:0] dp_mask,
   input  logic [5:0] blink_mask,
   output logic [6:0] seg_out,
   output logic       dp_out,
   output logic [5:0] an_out,
   output logic [2:0] digit_idx,
   output logic       frame_done
);

   localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam logic [5:0] AN_OFF = AN_ACTIVE_LOW ? 6'b111111 : 6'b000000;

   typedef enum logic {BLANK, SHOW} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [FW-1:0]   frame_cnt;
   logic            blink_phase;
   logic [6:0]      snap_seg;
   logic            snap_dp;
   logic            snap_blink;
   logic [6:0]      cur_dig;
   logic [5:0]      sel_onehot;

   always_comb begin
      cur_dig = SEG_OFF;
      case (digit_idx)
         3'd0: cur_dig = dig0;
         3'd1: cur_dig = dig1;
         3'd2: cur_dig = dig2;
         3'd3: cur_dig = dig3;
         3'd4: cur_dig = dig4;
         3'd5: cur_dig = dig5;
         default: cur_dig = SEG_OFF;
      endcase
      sel_onehot = 6'b000001 << digit_idx;
   end

   // Output registers follow the state of the previous cycle, so every
   // digit sees exactly BLANK_CYCLES dark cycles and DWELL_CYCLES lit ones.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= BLANK;
         cnt         <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b1;
         snap_seg    <= SEG_OFF;
         snap_dp     <= 1'b0;
         snap_blink  <= 1'b0;
         digit_idx   <= 3'd0;
         seg_out     <= SEG_OFF;
         dp_out      <= 1'b0;
         an_out      <= AN_OFF;
         frame_done  <= 1'b0;
      end else if (!enable) begin
         state      <= BLANK;
         cnt        <= '0;
         seg_out    <= SEG_OFF;
         dp_out     <= 1'b0;
         an_out     <= AN_OFF;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            BLANK: begin
               an_out  <= AN_OFF;
               seg_out <= SEG_OFF;
               dp_out  <= 1'b0;
               if (cnt == CW'(BLANK_CYCLES - 1)) begin
                  snap_seg   <= cur_dig;
                  snap_dp    <= dp_mask[digit_idx];
                  snap_blink <= blink_mask[digit_idx];
                  state      <= SHOW;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SHOW: begin
               an_out <= AN_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
               if (snap_blink && !blink_phase) begin
                  seg_out <= SEG_OFF;
                  dp_out  <= 1'b0;
               end else begin
                  seg_out <= snap_seg;
                  dp_out  <= snap_dp;
               end
               if (cnt == CW'(DWELL_CYCLES - 1)) begin
                  state <= BLANK;
                  cnt   <= '0;
                  if (digit_idx == 3'd5) begin
                     digit_idx  <= 3'd0;
                     frame_done <= 1'b1;
                     if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                     end else begin
                        frame_cnt <= frame_cnt + FW'(1);
                     end
                  end else begin
                     digit_idx <= digit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= BLANK;
         endcase
      end
   end

endmodule

// File: tb/tb_varredura_display.sv
// Directed bench for varredura_display with DWELL=4, BLANK=2, BLINK_FRAMES=2:
// a per-digit table drives a cycle model, hand sequences cover the corners.
module tb_varredura_display;

   typedef struct {
      logic [6:0] seg;
      logic [5:0] an;
      logic       dp;
      logic       blink;
   } vec_t;

   logic       clock, reset, enable;
   logic [6:0] dig0, dig1, dig2, dig3, dig4, dig5;
   logic [5:0] dp_mask, blink_mask;
   logic [6:0] seg_out;
   logic       dp_out;
   logic [5:0] an_out;
   logic [2:0] digit_idx;
   logic       frame_done;

   vec_t tbl[6];
   int   checks = 0;
   int   fails = 0;
   int   cyc = 0;
   bit   masksOn = 0;

   varredura_display #(
      .DWELL_CYCLES(4), .BLANK_CYCLES(2), .BLINK_FRAMES(2),
      .SEG_OFF(7'h7F), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4), .dig5(dig5),
      .dp_mask(dp_mask), .blink_mask(blink_mask),
      .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out),
      .digit_idx(digit_idx), .frame_done(frame_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clock);
      @(negedge clock);
      cyc = cyc + 1;
   endtask

   task automatic applyStimulus(input bit withMasks);
      dig0 = tbl[0].seg; dig1 = tbl[1].seg; dig2 = tbl[2].seg;
      dig3 = tbl[3].seg; dig4 = tbl[4].seg; dig5 = tbl[5].seg;
      masksOn = withMasks;
      for (int k = 0; k < 6; k++) begin
         dp_mask[k]    = withMasks & tbl[k].dp;
         blink_mask[k] = withMasks & tbl[k].blink;
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_an"},  32'(an_out),     32'h3F);
      checkOutput({tag, "_seg"}, 32'(seg_out),    32'h7F);
      checkOutput({tag, "_dp"},  32'(dp_out),     32'h0);
      checkOutput({tag, "_idx"}, 32'(digit_idx),  32'h0);
      checkOutput({tag, "_fd"},  32'(frame_done), 32'h0);
   endtask

   // Reset is released on a falling edge; the next rising edge is cycle 0.
   task automatic applyReset(input bit withMasks);
      reset  = 1'b1;
      enable = 1'b1;
      applyStimulus(withMasks);
      @(negedge clock);
      @(negedge clock);
      checkResetState("reset");
      reset = 1'b0;
      cyc = -1;
   endtask

   // Digit k occupies cycles 6k..6k+5 of each 36-cycle frame, lit on 6k+2..6k+5.
   task automatic checkModel();
      int p, k, r, f;
      logic lit, vis;
      logic [5:0] expAn;
      logic [6:0] expSeg;
      logic expDp;
      p = cyc % 36; k = p / 6; r = p % 6; f = cyc / 36;
      lit = (r >= 2);
      vis = !(masksOn && tbl[k].blink && ((f / 2) % 2 == 1));
      expAn  = lit ? tbl[k].an : 6'b111111;
      expSeg = (lit && vis) ? tbl[k].seg : 7'h7F;
      expDp  = lit && vis && masksOn && tbl[k].dp;
      checkOutput("an_out",     32'(an_out),     32'(expAn));
      checkOutput("seg_out",    32'(seg_out),    32'(expSeg));
      checkOutput("dp_out",     32'(dp_out),     32'(expDp));
      checkOutput("digit_idx",  32'(digit_idx),  32'(((cyc + 1) / 6) % 6));
      checkOutput("frame_done", 32'(frame_done), 32'(p == 35));
   endtask

   task automatic checkWindow(input int upTo);
      while (cyc < upTo) begin
         stepCycle();
         checkModel();
      end
   endtask

   task automatic runTo(input int target);
      while (cyc < target) stepCycle();
   endtask

   initial begin
      int prevK;
      tbl[0] = '{7'h40, 6'b111110, 1'b0, 1'b1};
      tbl[1] = '{7'h79, 6'b111101, 1'b0, 1'b1};
      tbl[2] = '{7'h24, 6'b111011, 1'b1, 1'b0};
      tbl[3] = '{7'h30, 6'b110111, 1'b0, 1'b0};
      tbl[4] = '{7'h19, 6'b101111, 1'b0, 1'b0};
      tbl[5] = '{7'h12, 6'b011111, 1'b0, 1'b0};
      reset = 1'b1;
      enable = 1'b0;
      applyStimulus(1'b0);

      // Basic scan for two frames; dig2 changes mid-slot in frame 1.
      $display("[TB] basic scan and snapshot");
      applyReset(1'b0);
      checkWindow(51);
      dig2 = 7'h00;
      checkWindow(71);
      runTo(86);
      for (int i = 0; i < 4; i++) begin
         checkOutput("snap_new_an",  32'(an_out),  32'h3B);
         checkOutput("snap_new_seg", 32'(seg_out), 32'h00);
         stepCycle();
      end

      // Blink digits 0,1 over six frames, decimal point on digit 2.
      $display("[TB] blink and decimal point");
      applyReset(1'b1);
      checkWindow(215);

      // Enable dropped during digit 3's lit slot for 10 cycles.
      $display("[TB] enable drop");
      applyReset(1'b0);
      runTo(21);
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         stepCycle();
         checkOutput("dis_an",  32'(an_out),     32'h3F);
         checkOutput("dis_seg", 32'(seg_out),    32'h7F);
         checkOutput("dis_idx", 32'(digit_idx),  32'h3);
         checkOutput("dis_fd",  32'(frame_done), 32'h0);
      end
      enable = 1'b1;
      for (int i = 0; i < 2; i++) begin
         stepCycle();
         checkOutput("reen_gap_an", 32'(an_out), 32'h3F);
      end
      for (int i = 0; i < 4; i++) begin
         stepCycle();
         checkOutput("reen_an",  32'(an_out),    32'h37);
         checkOutput("reen_seg", 32'(seg_out),   32'h30);
      end
      checkOutput("reen_idx", 32'(digit_idx), 32'h4);
      stepCycle();
      checkOutput("reen_after_an", 32'(an_out), 32'h3F);

      // Asynchronous reset between edges while digit 4 is lit.
      $display("[TB] async reset");
      applyReset(1'b0);
      runTo(27);
      checkOutput("pre_rst_an", 32'(an_out), 32'h2F);
      #2 reset = 1'b1;
      #1 checkResetState("async");
      applyReset(1'b0);
      checkWindow(35);

      // Long run with random disturbances: never two digits lit, never adjacent swap.
      $display("[TB] overlap run");
      prevK = -1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 15) == 0) enable = ~enable;
         if ($urandom_range(0, 7) == 0) dig0 = 7'($urandom_range(0, 127));
         stepCycle();
         checkOutput("onehot", 32'($countones(~an_out) <= 1), 32'h1);
         if (an_out != 6'h3F) begin
            int k;
            k = 0;
            for (int b = 0; b < 6; b++) if (!an_out[b]) k = b;
            if (prevK >= 0) checkOutput("adjacent", 32'(k), 32'(prevK));
            prevK = k;
         end else begin
            prevK = -1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
